// File: rtl/dm_banked.sv
// Byte-laned data memory with registered load/store responses and sub-word sign handling.
// Optional macro DM_BANKED_MISALIGN_SPLIT_EN enables misaligned access, split into two beats when crossing a word.
module dm_banked #(
  parameter int DEPTH = 64
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_type,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [32:0] LIMIT = 33'(4 * DEPTH);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] BEAT2 = 2'd1;
  localparam logic [1:0] RESP  = 2'd2;

  logic [1:0] state;
  logic [7:0] mem [0:3][0:DEPTH-1];

  // request decode
  logic [2:0]  size;
  logic        reserved, sx16, sx8;
  logic [1:0]  off;
  logic [32:0] last;
  logic        oor, misal, split, err, accept;

  // state held across a split access
  logic [1:0]    a_off;
  logic [2:0]    a_size;
  logic [31:0]   a_wdata;
  logic          a_we, a_sx16, a_sx8;
  logic [AW-1:0] a_word;
  logic [31:0]   raw;

  // per-beat lane control
  logic          cur_beat2, cur_we, cur_sx16, cur_sx8, active;
  logic [1:0]    cur_off;
  logic [2:0]    cur_size;
  logic [31:0]   cur_wdata;
  logic [AW-1:0] cur_word;
  logic [3:0]    lane_en;
  logic [1:0]    lane_idx [0:3];
  logic [7:0]    wbyte [0:3];
  logic [31:0]   merged;
  logic [31:0]   load_data;

  assign req_ready = rstn && (state == IDLE);
  assign accept    = req_valid && req_ready;
  assign off       = req_addr[1:0];

  always_comb begin
    size     = 3'd1;
    reserved = 1'b0;
    sx16     = 1'b0;
    sx8      = 1'b0;
    case (req_type)
      3'b000: size = 3'd4;
      3'b001: begin size = 3'd2; sx16 = 1'b1; end
      3'b010: size = 3'd2;
      3'b011: begin size = 3'd1; sx8 = 1'b1; end
      3'b100: size = 3'd1;
      default: reserved = 1'b1;
    endcase
  end

  // range check on the last byte touched; 33-bit sum avoids wrap at the top of the address space
  assign last = {1'b0, req_addr} + {30'd0, size} - 33'd1;
  assign oor  = (last >= LIMIT);

`ifdef DM_BANKED_MISALIGN_SPLIT_EN
  assign misal = 1'b0;
  assign split = ({2'b00, off} + {1'b0, size}) > 4'd4;
`else
  assign misal = ((size == 3'd4) && (off != 2'd0)) || ((size == 3'd2) && off[0]);
  assign split = 1'b0;
`endif

  assign err = reserved || misal || oor;

  always_comb begin
    cur_beat2 = (state == BEAT2);
    cur_off   = cur_beat2 ? a_off   : off;
    cur_size  = cur_beat2 ? a_size  : size;
    cur_wdata = cur_beat2 ? a_wdata : req_wdata;
    cur_we    = cur_beat2 ? a_we    : req_we;
    cur_sx16  = cur_beat2 ? a_sx16  : sx16;
    cur_sx8   = cur_beat2 ? a_sx8   : sx8;
    cur_word  = cur_beat2 ? (a_word + AW'(1)) : req_addr[AW+1:2];
    active    = (accept && !err) || (cur_beat2 && rstn);
  end

  // Lane l carries byte (l - off) mod 4 of the access; lanes below the offset belong to the next word.
  always_comb begin
    merged = cur_beat2 ? raw : '0;
    for (int unsigned l = 0; l < 4; l++) begin
      lane_idx[l] = 2'(l) - cur_off;
      wbyte[l]    = cur_wdata[{lane_idx[l], 3'b000} +: 8];
      lane_en[l]  = active && ({1'b0, lane_idx[l]} < cur_size) &&
                    (cur_beat2 ? (2'(l) < cur_off) : (2'(l) >= cur_off));
      if (lane_en[l] && !cur_we)
        merged[{lane_idx[l], 3'b000} +: 8] = mem[l][cur_word];
    end
  end

  always_comb begin
    if (cur_sx16)
      load_data = {{16{merged[15]}}, merged[15:0]};
    else if (cur_sx8)
      load_data = {{24{merged[7]}}, merged[7:0]};
    else
      load_data = merged;
  end

  always_ff @(posedge clk) begin
    for (int unsigned l = 0; l < 4; l++)
      if (lane_en[l] && cur_we)
        mem[l][cur_word] <= wbyte[l];
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      a_off   <= off;
      a_size  <= size;
      a_wdata <= req_wdata;
      a_we    <= req_we;
      a_sx16  <= sx16;
      a_sx8   <= sx8;
      a_word  <= req_addr[AW+1:2];
      raw     <= merged;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= IDLE;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          rsp_valid <= 1'b0;
          if (accept) begin
            if (!err && split) begin
              state <= BEAT2;
            end else begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= err;
              rsp_rdata <= (err || req_we) ? '0 : load_data;
            end
          end
        end
        BEAT2: begin
          state     <= RESP;
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b0;
          rsp_rdata <= a_we ? '0 : load_data;
        end
        default: begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dm_banked.sv
// Self-checking bench for dm_banked: directed scenarios plus random traffic against a byte-addressed model.
module tb_dm_banked;

  localparam int DEPTH = 64;
  localparam int LIMIT = 4 * DEPTH;
`ifdef DM_BANKED_MISALIGN_SPLIT_EN
  localparam bit SPLIT_EN = 1'b1;
`else
  localparam bit SPLIT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [2:0]  req_type = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  logic [7:0] model [0:LIMIT-1];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dm_banked #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_type(req_type), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: byte-addressed memory; updates the model and returns the expected response.
  task automatic model_req(input logic we, input logic [31:0] addr, input logic [2:0] typ,
                           input logic [31:0] wdata, output logic err, output logic [31:0] rdata,
                           output int lat);
    int size = 1;
    bit sgn = 0, reserved = 0, misal;
    int off = int'(addr % 4);
    longint lastb;
    case (typ)
      3'd0: size = 4;
      3'd1: begin size = 2; sgn = 1; end
      3'd2: size = 2;
      3'd3: begin size = 1; sgn = 1; end
      3'd4: size = 1;
      default: reserved = 1;
    endcase
    misal = !SPLIT_EN && ((size == 4 && off != 0) || (size == 2 && off % 2 != 0));
    lastb = longint'(addr) + size - 1;
    err = reserved || misal || (lastb >= LIMIT);
    lat = (!err && off + size > 4) ? 2 : 1;
    rdata = '0;
    if (!err) begin
      for (int i = 0; i < size; i++) begin
        if (we) model[int'(addr) + i] = wdata[8*i +: 8];
        else    rdata[8*i +: 8] = model[int'(addr) + i];
      end
      if (!we && sgn && size == 2 && rdata[15]) rdata = rdata | 32'hFFFF_0000;
      if (!we && sgn && size == 1 && rdata[7])  rdata = rdata | 32'hFFFF_FF00;
    end
  endtask

  task automatic do_req(input logic we, input logic [31:0] addr, input logic [2:0] typ,
                        input logic [31:0] wdata, input string tag, output logic [31:0] got);
    logic e;
    logic [31:0] er;
    int el, lat, w;
    model_req(we, addr, typ, wdata, e, er, el);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_type = typ; req_wdata = wdata;
    w = 0;
    while (!req_ready && w < 10) begin @(negedge clk); w++; end
    if (!req_ready) check({tag, "_ready_timeout"}, {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!rsp_valid && lat < 6);
    check({tag, "_latency"}, lat, el);
    check({tag, "_err"}, {31'd0, rsp_err}, {31'd0, e});
    check({tag, "_rdata"}, rsp_rdata, er);
    got = rsp_rdata;
  endtask

  initial begin
    logic [31:0] got, a, d, q[$];
    logic [2:0]  t;
    int sent, pulses;
    string tag;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_ready", {31'd0, req_ready}, 32'd0);
    check("rst_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rdata", rsp_rdata, 32'd0);
    check("rst_err", {31'd0, rsp_err}, 32'd0);
    rstn = 1'b1;
    @(negedge clk);
    check("rel_ready", {31'd0, req_ready}, 32'd1);

    // fill every word so the model starts from known contents
    for (int i = 0; i < DEPTH; i++)
      do_req(1'b1, 32'(4 * i), 3'd0, $urandom, "init", got);

    // directed scenarios
    do_req(1'b1, 32'h04, 3'd0, 32'h8899AABB, "s_st_w", got);
    do_req(1'b0, 32'h04, 3'd0, 32'h0, "s_ld_w", got);
    check("s_ld_w_const", got, 32'h8899AABB);
    do_req(1'b0, 32'h07, 3'd4, 32'h0, "s_ld_bu", got);
    check("s_ld_bu_const", got, 32'h00000088);
    do_req(1'b0, 32'h06, 3'd1, 32'h0, "s_ld_hs", got);
    check("s_ld_hs_const", got, 32'hFFFF8899);
    do_req(1'b0, 32'h06, 3'd2, 32'h0, "s_ld_hu", got);
    check("s_ld_hu_const", got, 32'h00008899);
    do_req(1'b1, 32'h05, 3'd3, 32'h55, "s_st_b", got);
    do_req(1'b0, 32'h04, 3'd0, 32'h0, "s_ld_w2", got);
    check("s_ld_w2_const", got, 32'h889955BB);
    do_req(1'b0, 32'h100, 3'd0, 32'h0, "oor_ld", got);
    do_req(1'b1, 32'hFE, 3'd0, 32'hDEADBEEF, "oor_st", got);
    do_req(1'b0, 32'hFC, 3'd0, 32'h0, "oor_chk", got);
    do_req(1'b1, 32'hFD, 3'd1, 32'h1234, "oor_hs", got);
    do_req(1'b1, 32'h08, 3'd5, 32'h12345678, "resv_st", got);
    do_req(1'b0, 32'h08, 3'd7, 32'h0, "resv_ld", got);
    do_req(1'b0, 32'h08, 3'd0, 32'h0, "resv_chk", got);
    do_req(1'b1, 32'h03, 3'd0, 32'h11223344, "mis_st", got);
    do_req(1'b0, 32'h00, 3'd0, 32'h0, "mis_ld0", got);
    do_req(1'b0, 32'h04, 3'd0, 32'h0, "mis_ld4", got);
`ifdef DM_BANKED_MISALIGN_SPLIT_EN
    check("mis_ld4_const", {8'd0, got[23:0]}, 32'h00112233);
`endif
    do_req(1'b0, 32'h0D, 3'd1, 32'h0, "mis_h1", got);

    // random traffic, including the region just past the end and wild addresses
    for (int i = 0; i < 300; i++) begin
      t = 3'($urandom_range(0, 7));
      a = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, LIMIT + 15));
      d = $urandom;
      tag = $sformatf("rnd%0d_a%0h_t%0d", i, a, t);
      do_req(1'($urandom_range(0, 1)), a, t, d, tag, got);
    end

    // back-to-back: req_valid held high, inputs change only once accepted
    sent = 0; pulses = 0;
    @(negedge clk);
    for (int c = 0; c < 16; c++) begin
      if (rsp_valid) begin
        pulses++;
        if (q.size() > 0) check("b2b_rdata", rsp_rdata, q.pop_front());
      end
      if (req_ready) begin
        if (sent < 3) begin
          logic e;
          logic [31:0] er;
          int el;
          a = 32'(4 * $urandom_range(0, DEPTH - 1));
          model_req(1'b0, a, 3'd0, 32'h0, e, er, el);
          q.push_back(er);
          req_valid = 1'b1; req_we = 1'b0; req_addr = a; req_type = 3'd0;
          sent++;
        end else begin
          req_valid = 1'b0;
        end
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    check("b2b_pulses", pulses, 32'd3);

    // reset pulse mid-access: in the split build it lands in the second beat
    @(negedge clk);
    a = SPLIT_EN ? 32'h21 : 32'h20;
    d = $urandom;
    req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_type = 3'd0; req_wdata = d;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int i = 0; i < 4; i++)
      if (!SPLIT_EN || (int'(a % 4) + i) < 4) model[int'(a) + i] = d[8*i +: 8];
    @(negedge clk);
    if (SPLIT_EN) check("b2_no_early_rsp", {31'd0, rsp_valid}, 32'd0);
    rstn = 1'b0;
    #1 check("rstlow_ready", {31'd0, req_ready}, 32'd0);
    pulses = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (rsp_valid) pulses++;
    end
    check("rst_abandon", pulses, 32'd0);
    rstn = 1'b1;
    @(negedge clk);
    check("rst_rel_ready", {31'd0, req_ready}, 32'd1);
    do_req(1'b0, 32'h20, 3'd0, 32'h0, "post_rst_w20", got);
    do_req(1'b0, 32'h24, 3'd0, 32'h0, "post_rst_w24", got);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dm_banked.md
DM_BANKED -- requirements
Module: dm_banked

Interface
REQ-001 The block SHALL have parameter DEPTH, default 64, meaning memory size in 32-bit words; it is a power of two, at least 4.
REQ-002 The block SHALL have derived localparam AW = log2(DEPTH), meaning the word-index width.
REQ-003 The block SHALL have port clk  in  1  meaning the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rstn  in  1  meaning reset; it is synchronous and active-low.
REQ-005 The block SHALL have port req_valid  in  1  meaning a request is presented.
REQ-006 The block SHALL have port req_ready  out  1  meaning the block can accept; the transfer occurs on an edge with req_valid and req_ready both high.
REQ-007 The block SHALL have port req_we  in  1  meaning 1 = store, 0 = load.
REQ-008 The block SHALL have port req_addr  in  32  meaning the byte address.
REQ-009 The block SHALL have port req_type  in  3  meaning access type: 000 word, 001 half signed, 010 half unsigned, 011 byte signed, 100 byte unsigned.
REQ-010 The block SHALL have port req_wdata  in  32  meaning store data, right-aligned.
REQ-011 The block SHALL have port rsp_valid  out  1  meaning a one-cycle response pulse for every accepted request, load or store.
REQ-012 The block SHALL have port rsp_rdata  out  32  meaning load data, extended per req_type; it is 0 for stores and errors.
REQ-013 The block SHALL have port rsp_err  out  1  meaning the request was rejected; it is qualified by rsp_valid.

Function
REQ-014 Storage SHALL be four byte lanes of DEPTH entries each, little-endian: byte address A maps to lane A[1:0], entry A[AW+1:2].
REQ-015 Loads SHALL read synchronously through registered outputs; there is no combinational path from req_* to rsp_*.
REQ-016 FSM states SHALL be IDLE, BEAT2 and RESP: IDLE is the only state with req_ready = 1.
REQ-017 Single-beat acceptance at edge N SHALL move the FSM to RESP and assert rsp_valid for the cycle after edge N; the FSM returns to IDLE at edge N+1, so back-to-back throughput is one request per 2 cycles.
REQ-018 Stores SHALL write only the byte lanes selected by type and address; word stores write 4 bytes, half stores 2, byte stores 1.
REQ-019 Half-signed and byte-signed loads SHALL sign-extend from bit 15 and bit 7 respectively; the unsigned variants SHALL zero-extend.
REQ-020 Out-of-range accesses SHALL return rsp_err = 1, perform no write and return rsp_rdata = 0; an access is out of range if any byte touched has address >= 4*DEPTH.
REQ-021 A reserved req_type (101-111) SHALL return rsp_err = 1 and perform no write.
REQ-022 Error checks SHALL be evaluated in full at acceptance, before any byte is written.
REQ-023 When req_valid is high and req_ready is low, the request SHALL be ignored; the requester holds it.

Reset
REQ-024 While rstn = 0 at a rising edge, the block SHALL set the FSM to IDLE, rsp_valid = 0, rsp_rdata = 0 and rsp_err = 0.
REQ-025 req_ready SHALL be 0 in any cycle where rstn is low, and 1 in the first cycle after rstn returns high.
REQ-026 Memory contents SHALL NOT be reset.
REQ-027 Reset in BEAT2 SHALL abandon the second beat; bytes written in the first beat remain, and no response is issued.

Configuration
REQ-028 Macro DM_BANKED_MISALIGN_SPLIT_EN SHALL control misaligned accesses as follows.
REQ-029 Without the macro, a word access with addr[1:0] != 0 or a half access with addr[0] != 0 SHALL return rsp_err = 1 with no write.
REQ-030 With the macro, a misaligned access contained in one word (half at offset 1) SHALL complete in one beat.
REQ-031 With the macro, a misaligned access crossing a word boundary (half at offset 3, word at offset 1-3) SHALL split into two beats via BEAT2.
REQ-032 For a split access, beat 1 SHALL handle the lower word and beat 2 the next word; rsp_valid comes 2 cycles after acceptance, and req_ready is 0 during BEAT2.
REQ-033 A split access whose upper word is out of range SHALL return an error with no write.

Verification
REQ-034 Scenario: store word 0x8899AABB at address 0x04, then load word at 0x04 -> rsp_rdata = 0x8899AABB; then load byte unsigned at 0x07 -> 0x00000088.
REQ-035 Scenario: load half signed at 0x06 after the store above -> 0xFFFF8899; load half unsigned at 0x06 -> 0x00008899.
REQ-036 Scenario: store byte 0x55 at 0x05, then load word at 0x04 -> 0x889955BB; lanes 0, 2 and 3 unchanged.
REQ-037 Scenario: with DEPTH = 64, load word at 0x100 -> rsp_err = 1, rsp_rdata = 0; store word at 0xFE -> rsp_err = 1 in both builds, memory unchanged.
REQ-038 Scenario: store word 0x11223344 at 0x03 -> without macro rsp_err = 1 and 0x00-0x07 unchanged; with macro rsp_err = 0, rsp_valid 2 cycles after acceptance, and a load word at 0x04 returns 0x00112233 in its low 3 bytes, i.e. 0x--112233.
REQ-039 Scenario: hold req_valid high continuously with 3 loads -> exactly 3 rsp_valid pulses; rstn pulsed low during BEAT2 -> no response, req_ready = 1 one cycle after release.
